// File: rtl/ace_mem_pkg.sv
// ace_mem_pkg: FSM states and ACE response/snoop encodings shared by the memory responder.
package ace_mem_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RD_RESP, ST_WR_DATA, ST_WR_RESP} state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [3:0] SNOOP_READ_SHARED = 4'b0001;
  localparam logic [3:0] SNOOP_MAKE_UNIQUE = 4'b1100;
endpackage

// File: rtl/ace_mem_array.sv
// ace_mem_array: async-reset word register file, one write port and one combinational read port.
module ace_mem_array #(
  parameter int WIDTH_D = 32,
  parameter int DEPTH = 8,
  parameter logic [WIDTH_D-1:0] INIT_WORD = 'hDEEDFEED,
  parameter int IW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_we,
  input  logic [IW-1:0] i_waddr,
  input  logic [WIDTH_D-1:0] i_wdata,
  input  logic [IW-1:0] i_raddr,
  output logic [WIDTH_D-1:0] o_rdata
);
  logic [WIDTH_D-1:0] r_mem [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < DEPTH; i++) r_mem[i] <= INIT_WORD;
    else if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/ace_mem_responder.sv
// ace_mem_responder: single-beat ACE AR/R + AW/W/B memory responder with read/write tie alternation.
// Optional pseudo-random ready stalls when ACE_MEM_READY_STALL_EN is defined.
module ace_mem_responder import ace_mem_pkg::*; #(
  parameter int WIDTH_A = 32,
  parameter int WIDTH_D = 32,
  parameter int DEPTH = 8,
  parameter logic [WIDTH_D-1:0] INIT_WORD = 'hDEEDFEED,
  parameter logic [7:0] STALL_SEED = 8'hA5
) (
  input  logic clk,
  input  logic rst,
  input  logic AR_VALID,
  output logic AR_READY,
  input  logic [WIDTH_A-1:0] AR_ADDR,
  input  logic AR_ID,
  input  logic [7:0] AR_LEN,
  input  logic [3:0] AR_SNOOP,
  output logic R_VALID,
  input  logic R_READY,
  output logic R_ID,
  output logic R_LAST,
  output logic [3:0] RRESP,
  output logic [WIDTH_D-1:0] RDATA,
  input  logic AW_VALID,
  output logic AW_READY,
  input  logic [WIDTH_A-1:0] AW_ADDR,
  input  logic AW_ID,
  input  logic [7:0] AW_LEN,
  input  logic W_VALID,
  output logic W_READY,
  input  logic [WIDTH_D-1:0] W_DATA,
  input  logic W_LAST,
  output logic B_VALID,
  input  logic B_READY,
  output logic [1:0] BRESP
);
  localparam int IW = $clog2(DEPTH);
  state_t r_state;
  logic r_prefer_wr, r_wr_err, r_wr_id;
  logic [IW-1:0] r_wr_idx;
  logic w_go, w_idle, w_ar_hs, w_aw_hs, w_w_hs, w_ar_err, w_aw_err, w_we;
  logic [WIDTH_D-1:0] w_rdata;
`ifdef ACE_MEM_READY_STALL_EN
  logic [7:0] r_lfsr;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_lfsr <= STALL_SEED;
    else r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_go = r_lfsr[0];
`else
  assign w_go = 1'b1;
`endif
  assign w_idle = r_state == ST_IDLE;
  assign AR_READY = w_idle && !(AW_VALID && r_prefer_wr) && w_go;
  assign AW_READY = w_idle && !(AR_VALID && !r_prefer_wr) && w_go;
  assign W_READY = r_state == ST_WR_DATA && w_go;
  assign w_ar_hs = AR_VALID && AR_READY;
  assign w_aw_hs = AW_VALID && AW_READY;
  assign w_w_hs = W_VALID && W_READY;
  assign w_ar_err = AR_ADDR >= WIDTH_A'(DEPTH * 4) || AR_LEN != 8'd0;
  assign w_aw_err = AW_ADDR >= WIDTH_A'(DEPTH * 4) || AW_LEN != 8'd0;
  // A truncated write (W_LAST low) is answered with SLVERR and never reaches memory.
  assign w_we = w_w_hs && !r_wr_err && W_LAST;
  ace_mem_array #(.WIDTH_D(WIDTH_D), .DEPTH(DEPTH), .INIT_WORD(INIT_WORD)) u_array (
    .clk(clk),
    .rst(rst),
    .i_we(w_we),
    .i_waddr(r_wr_idx),
    .i_wdata(W_DATA),
    .i_raddr(AR_ADDR[IW+1:2]),
    .o_rdata(w_rdata)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= ST_IDLE;
      r_prefer_wr <= 1'b0;
      r_wr_err <= 1'b0;
      r_wr_id <= 1'b0;
      r_wr_idx <= '0;
      R_VALID <= 1'b0;
      R_ID <= 1'b0;
      R_LAST <= 1'b0;
      RRESP <= 4'd0;
      RDATA <= '0;
      B_VALID <= 1'b0;
      BRESP <= 2'd0;
    end else
      case (r_state)
        ST_IDLE: begin
          if (AR_VALID && AW_VALID && (w_ar_hs || w_aw_hs)) r_prefer_wr <= !r_prefer_wr;
          if (w_ar_hs) begin
            r_state <= ST_RD_RESP;
            R_VALID <= 1'b1;
            R_ID <= AR_ID;
            R_LAST <= 1'b1;
            RRESP <= {2'b00, w_ar_err ? RESP_SLVERR : RESP_OKAY};
            RDATA <= (w_ar_err || AR_SNOOP == SNOOP_MAKE_UNIQUE) ? '0 : w_rdata;
          end else if (w_aw_hs) begin
            r_state <= ST_WR_DATA;
            r_wr_err <= w_aw_err;
            r_wr_id <= AW_ID;
            r_wr_idx <= AW_ADDR[IW+1:2];
          end
        end
        ST_RD_RESP: if (R_READY) begin
          r_state <= ST_IDLE;
          R_VALID <= 1'b0;
          R_LAST <= 1'b0;
        end
        ST_WR_DATA: if (w_w_hs) begin
          r_state <= ST_WR_RESP;
          B_VALID <= 1'b1;
          BRESP <= (r_wr_err || !W_LAST) ? RESP_SLVERR : RESP_OKAY;
        end
        ST_WR_RESP: if (B_READY) begin
          r_state <= ST_IDLE;
          B_VALID <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
endmodule

// File: tb/tb_ace_mem_responder.sv
// tb_ace_mem_responder: directed self-checking bench for ace_mem_responder.
module tb_ace_mem_responder;
  import ace_mem_pkg::*;
  logic clk = 1'b0, rst;
  logic AR_VALID, AR_READY, AR_ID, R_VALID, R_READY, R_ID, R_LAST;
  logic [31:0] AR_ADDR, RDATA, AW_ADDR, W_DATA;
  logic [7:0] AR_LEN, AW_LEN;
  logic [3:0] AR_SNOOP, RRESP;
  logic AW_VALID, AW_READY, AW_ID, W_VALID, W_READY, W_LAST, B_VALID, B_READY;
  logic [1:0] BRESP;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  ace_mem_responder dut (
    .clk(clk), .rst(rst),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR), .AR_ID(AR_ID),
    .AR_LEN(AR_LEN), .AR_SNOOP(AR_SNOOP),
    .R_VALID(R_VALID), .R_READY(R_READY), .R_ID(R_ID), .R_LAST(R_LAST), .RRESP(RRESP), .RDATA(RDATA),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR), .AW_ID(AW_ID), .AW_LEN(AW_LEN),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA), .W_LAST(W_LAST),
    .B_VALID(B_VALID), .B_READY(B_READY), .BRESP(BRESP)
  );

  task automatic issue_ar(input logic [31:0] a, input logic [3:0] sn, input logic [7:0] ln, input logic id, output logic to);
    @(negedge clk);
    AR_VALID = 1'b1; AR_ADDR = a; AR_SNOOP = sn; AR_LEN = ln; AR_ID = id;
    #1;
    for (int i = 0; i < 16 && !AR_READY; i++) begin @(negedge clk); #1; end
    to = !AR_READY;
    @(negedge clk);
    AR_VALID = 1'b0;
  endtask

  task automatic finish_read(output logic [31:0] d, output logic [3:0] rr, output logic rid, output logic rl,
                             output logic imm, output logic to);
    imm = R_VALID;
    for (int i = 0; i < 16 && !R_VALID; i++) @(negedge clk);
    to = !R_VALID;
    d = RDATA; rr = RRESP; rid = R_ID; rl = R_LAST;
    R_READY = 1'b1;
    @(negedge clk);
    R_READY = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] sn, input logic [7:0] ln, input logic id,
                         output logic [31:0] d, output logic [3:0] rr, output logic rid, output logic rl,
                         output logic imm, output logic to);
    logic to_a, to_r;
    issue_ar(a, sn, ln, id, to_a);
    finish_read(d, rr, rid, rl, imm, to_r);
    to = to_a | to_r;
  endtask

  task automatic issue_aw(input logic [31:0] a, input logic [7:0] ln, output logic to);
    @(negedge clk);
    AW_VALID = 1'b1; AW_ADDR = a; AW_LEN = ln; AW_ID = 1'b0;
    #1;
    for (int i = 0; i < 16 && !AW_READY; i++) begin @(negedge clk); #1; end
    to = !AW_READY;
    @(negedge clk);
    AW_VALID = 1'b0;
  endtask

  task automatic finish_write(input logic [31:0] d, input logic last, output logic [1:0] br,
                              output logic imm, output logic to);
    W_VALID = 1'b1; W_DATA = d; W_LAST = last;
    #1;
    for (int i = 0; i < 16 && !W_READY; i++) begin @(negedge clk); #1; end
    to = !W_READY;
    @(negedge clk);
    W_VALID = 1'b0;
    imm = B_VALID;
    for (int i = 0; i < 16 && !B_VALID; i++) @(negedge clk);
    to = to | !B_VALID;
    br = BRESP;
    B_READY = 1'b1;
    @(negedge clk);
    B_READY = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] ln, input logic [31:0] d, input logic last,
                          output logic [1:0] br, output logic imm, output logic to);
    logic to_a, to_w;
    issue_aw(a, ln, to_a);
    finish_write(d, last, br, imm, to_w);
    to = to_a | to_w;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({R_VALID, B_VALID} !== 2'b00) begin errors++; $display("FAIL reset_valid got=%b exp=00", {R_VALID, B_VALID}); end
    checks++; if ({R_ID, R_LAST, RRESP, BRESP} !== 8'd0) begin errors++; $display("FAIL reset_fields got=%h exp=00", {R_ID, R_LAST, RRESP, BRESP}); end
    checks++; if (RDATA !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", RDATA); end
    checks++; if (W_READY !== 1'b0) begin errors++; $display("FAIL reset_wready got=%b exp=0", W_READY); end
    rst = 1'b0;
  endtask

  task automatic test_read_basic;
    logic [31:0] d; logic [3:0] rr; logic rid, rl, imm, to;
    do_read(32'h8, SNOOP_READ_SHARED, 8'd0, 1'b1, d, rr, rid, rl, imm, to);
    checks++; if ({to, imm} !== 2'b01) begin errors++; $display("FAIL rd_latency got=%b exp=01", {to, imm}); end
    checks++; if (d !== 32'hDEEDFEED) begin errors++; $display("FAIL rd_data got=%h exp=deedfeed", d); end
    checks++; if ({rr, rl, rid} !== 6'b000011) begin errors++; $display("FAIL rd_resp_last_id got=%b exp=000011", {rr, rl, rid}); end
    checks++; if (R_VALID !== 1'b0) begin errors++; $display("FAIL rd_valid_drop got=%b exp=0", R_VALID); end
  endtask

  task automatic test_write_read;
    logic [31:0] d; logic [3:0] rr; logic [1:0] br; logic rid, rl, imm, to;
    @(negedge clk);
    W_VALID = 1'b1; W_DATA = 32'hBAD0BAD0; W_LAST = 1'b1;
    #1;
    checks++; if (W_READY !== 1'b0) begin errors++; $display("FAIL w_before_aw got=%b exp=0", W_READY); end
    do_write(32'hC, 8'd0, 32'hABCDABCD, 1'b1, br, imm, to);
    checks++; if ({to, imm, br} !== 4'b0100) begin errors++; $display("FAIL wr_bresp got=%b exp=0100", {to, imm, br}); end
    do_read(32'hC, SNOOP_READ_SHARED, 8'd0, 1'b0, d, rr, rid, rl, imm, to);
    checks++; if ({to, d, rr} !== {1'b0, 32'hABCDABCD, 4'd0}) begin errors++; $display("FAIL raw_data got=%h/%h exp=abcdabcd/0", d, rr); end
  endtask

  task automatic test_tie;
    logic [31:0] d; logic [3:0] rr; logic [1:0] br; logic rid, rl, imm, to;
    logic [1:0] exp_rdy [3] = '{2'b10, 2'b01, 2'b10};
    logic [31:0] exp_d [3] = '{32'hDEEDFEED, 32'h0, 32'h11112222};
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      AR_VALID = 1'b1; AR_ADDR = 32'h10; AR_SNOOP = SNOOP_READ_SHARED; AR_LEN = 8'd0; AR_ID = 1'b0;
      AW_VALID = 1'b1; AW_ADDR = 32'h10; AW_LEN = 8'd0; AW_ID = 1'b1;
      #1;
      checks++; if ({AR_READY, AW_READY} !== exp_rdy[t]) begin errors++; $display("FAIL tie%0d_ready got=%b exp=%b", t, {AR_READY, AW_READY}, exp_rdy[t]); end
      @(negedge clk);
      AR_VALID = 1'b0; AW_VALID = 1'b0;
      if (t == 1) begin
        finish_write(32'h11112222, 1'b1, br, imm, to);
        checks++; if ({to, imm, br} !== 4'b0100) begin errors++; $display("FAIL tie%0d_bresp got=%b exp=0100", t, {to, imm, br}); end
      end else begin
        finish_read(d, rr, rid, rl, imm, to);
        checks++; if ({to, imm, d} !== {2'b01, exp_d[t]}) begin errors++; $display("FAIL tie%0d_rdata got=%h exp=%h", t, d, exp_d[t]); end
      end
    end
  endtask

  task automatic test_errors;
    logic [31:0] d; logic [3:0] rr; logic [1:0] br; logic rid, rl, imm, to;
    do_read(32'h0100_0018, SNOOP_READ_SHARED, 8'd0, 1'b0, d, rr, rid, rl, imm, to);
    checks++; if ({to, rr, d} !== {1'b0, 4'b0010, 32'd0}) begin errors++; $display("FAIL rd_oor got=%h/%h exp=2/0", rr, d); end
    do_write(32'h0100_000C, 8'd0, 32'h55555555, 1'b1, br, imm, to);
    checks++; if ({to, br} !== 3'b010) begin errors++; $display("FAIL wr_oor got=%b exp=10", br); end
    do_read(32'hC, SNOOP_READ_SHARED, 8'd0, 1'b0, d, rr, rid, rl, imm, to);
    checks++; if (d !== 32'hABCDABCD) begin errors++; $display("FAIL oor_untouched got=%h exp=abcdabcd", d); end
    do_read(32'h8, SNOOP_READ_SHARED, 8'd1, 1'b0, d, rr, rid, rl, imm, to);
    checks++; if ({to, rr, d} !== {1'b0, 4'b0010, 32'd0}) begin errors++; $display("FAIL rd_len got=%h/%h exp=2/0", rr, d); end
    do_write(32'h8, 8'd0, 32'h66666666, 1'b0, br, imm, to);
    checks++; if ({to, br} !== 3'b010) begin errors++; $display("FAIL wr_nolast got=%b exp=10", br); end
    do_write(32'h8, 8'd3, 32'h77777777, 1'b1, br, imm, to);
    checks++; if ({to, br} !== 3'b010) begin errors++; $display("FAIL wr_len got=%b exp=10", br); end
    do_read(32'h8, SNOOP_READ_SHARED, 8'd0, 1'b0, d, rr, rid, rl, imm, to);
    checks++; if ({rr, d} !== {4'd0, 32'hDEEDFEED}) begin errors++; $display("FAIL dropped_write got=%h/%h exp=0/deedfeed", rr, d); end
    do_read(32'hC, SNOOP_MAKE_UNIQUE, 8'd0, 1'b0, d, rr, rid, rl, imm, to);
    checks++; if ({to, rr, d} !== {1'b0, 4'd0, 32'd0}) begin errors++; $display("FAIL make_unique got=%h/%h exp=0/0", rr, d); end
    do_read(32'hC, SNOOP_READ_SHARED, 8'd0, 1'b0, d, rr, rid, rl, imm, to);
    checks++; if (d !== 32'hABCDABCD) begin errors++; $display("FAIL mu_untouched got=%h exp=abcdabcd", d); end
  endtask

  task automatic test_r_stall;
    logic [31:0] d; logic [3:0] rr; logic rid, rl, imm, to, to_a;
    issue_ar(32'hC, SNOOP_READ_SHARED, 8'd0, 1'b1, to_a);
    AR_VALID = 1'b1; AR_ADDR = 32'h8; AR_ID = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({AR_READY, R_VALID, R_ID, RRESP, RDATA} !== {3'b011, 4'd0, 32'hABCDABCD}) begin
        errors++; $display("FAIL r_hold%0d got=%b%b%b/%h/%h exp=011/0/abcdabcd", c, AR_READY, R_VALID, R_ID, RRESP, RDATA);
      end
      @(negedge clk);
    end
    AR_VALID = 1'b0;
    finish_read(d, rr, rid, rl, imm, to);
    checks++; if ({to_a, to, d, rid} !== {2'b00, 32'hABCDABCD, 1'b1}) begin errors++; $display("FAIL r_hold_final got=%h/%b exp=abcdabcd/1", d, rid); end
  endtask

  task automatic test_reset_mid_write;
    logic [31:0] d; logic [3:0] rr; logic [1:0] br; logic rid, rl, imm, to;
    do_write(32'h0, 8'd0, 32'h12345678, 1'b1, br, imm, to);
    issue_aw(32'h4, 8'd0, to);
    #1;
    checks++; if ({to, W_READY} !== 2'b01) begin errors++; $display("FAIL pre_rst_wdata got=%b exp=01", {to, W_READY}); end
    W_DATA = 32'h99999999; W_LAST = 1'b1;
    rst = 1'b1;
    #1;
    checks++; if ({B_VALID, W_READY} !== 2'b00) begin errors++; $display("FAIL mid_rst got=%b exp=00", {B_VALID, W_READY}); end
    @(negedge clk);
    rst = 1'b0;
    do_read(32'h0, SNOOP_READ_SHARED, 8'd0, 1'b0, d, rr, rid, rl, imm, to);
    checks++; if (d !== 32'hDEEDFEED) begin errors++; $display("FAIL rst_word0 got=%h exp=deedfeed", d); end
    do_read(32'h4, SNOOP_READ_SHARED, 8'd0, 1'b0, d, rr, rid, rl, imm, to);
    checks++; if (d !== 32'hDEEDFEED) begin errors++; $display("FAIL rst_word1 got=%h exp=deedfeed", d); end
    do_read(32'hC, SNOOP_READ_SHARED, 8'd0, 1'b0, d, rr, rid, rl, imm, to);
    checks++; if (d !== 32'hDEEDFEED) begin errors++; $display("FAIL rst_word3 got=%h exp=deedfeed", d); end
    do_write(32'h4, 8'd0, 32'h77778888, 1'b1, br, imm, to);
    checks++; if ({to, br} !== 3'b000) begin errors++; $display("FAIL post_rst_aw got=%b exp=000", {to, br}); end
    do_read(32'h4, SNOOP_READ_SHARED, 8'd0, 1'b0, d, rr, rid, rl, imm, to);
    checks++; if (d !== 32'h77778888) begin errors++; $display("FAIL post_rst_data got=%h exp=77778888", d); end
  endtask

  initial begin
    rst = 1'b1;
    AR_VALID = 1'b0; AR_ADDR = '0; AR_ID = 1'b0; AR_LEN = '0; AR_SNOOP = '0; R_READY = 1'b0;
    AW_VALID = 1'b0; AW_ADDR = '0; AW_ID = 1'b0; AW_LEN = '0;
    W_VALID = 1'b0; W_DATA = '0; W_LAST = 1'b0; B_READY = 1'b0;
    test_reset;
    test_read_basic;
    test_write_read;
    test_tie;
    test_errors;
    test_r_stall;
    test_reset_mid_write;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ace_mem_responder.md
Name: ace_mem_responder

Overview:
- Synthesizable main-memory responder for the cache's ACE read and write channels: AR/R and AW/W/B.
- Sits at the interconnect end, opposite the cache's initiator ports, and replaces the behavioural memory model in system benches.
- Single-beat transfers into a small word-addressed memory.
- Arbitrates reads against writes and returns OKAY or SLVERR responses.

Parameters:
- WIDTH_A, 32, address width
- WIDTH_D, 32, data width
- DEPTH, 8, memory words (power of 2); index = ADDR[$clog2(DEPTH)+1:2]
- INIT_WORD, 32'hDEEDFEED, reset value of every word
- STALL_SEED, 8'hA5, LFSR seed (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- AR_VALID  in  1  read address valid
- AR_READY  out  1  read address accepted
- AR_ADDR  in  WIDTH_A  read address
- AR_ID  in  1  read ID
- AR_LEN  in  8  burst length-1; only 0 supported
- AR_SNOOP  in  4  ACE read snoop type
- R_VALID  out  1  read data valid
- R_READY  in  1  read data accepted
- R_ID  out  1  echoed AR_ID
- R_LAST  out  1  last beat; always 1 when R_VALID
- RRESP  out  4  [1:0] OKAY 00 / SLVERR 10; [3:2] always 00
- RDATA  out  WIDTH_D  read data
- AW_VALID  in  1  write address valid
- AW_READY  out  1  write address accepted
- AW_ADDR  in  WIDTH_A  write address
- AW_ID  in  1  write ID
- AW_LEN  in  8  burst length-1; only 0 supported
- W_VALID  in  1  write data valid
- W_READY  out  1  write data accepted
- W_DATA  in  WIDTH_D  write data
- W_LAST  in  1  last write beat
- B_VALID  out  1  write response valid
- B_READY  in  1  write response accepted
- BRESP  out  2  OKAY 00 / SLVERR 10

Behaviour:
- Reset (async, rst=1):
  - state IDLE, prefer_wr=0.
  - All VALID outputs 0; R_ID, R_LAST, RRESP, RDATA, BRESP all 0.
  - Every memory word set to INIT_WORD.
  - Reset mid-transaction abandons it; no partial write is committed.
- FSM states:
  - IDLE: accept AR or AW.
  - RD_RESP: drive R.
  - WR_DATA: wait for W.
  - WR_RESP: drive B.
- Ready signals:
  - AR_READY = IDLE && !(AW_VALID && prefer_wr).
  - AW_READY = IDLE && !(AR_VALID && !prefer_wr).
  - W_READY = WR_DATA.
  - At most one address handshake per cycle.
- Tie break (AR_VALID && AW_VALID in IDLE):
  - Granted side per prefer_wr.
  - prefer_wr toggles after each tie, so neither channel starves.
  - A non-tie grant leaves prefer_wr unchanged.
- Read path (AR handshake at edge N):
  - Registered R_VALID=1 from cycle N+1; R_ID=AR_ID, R_LAST=1.
  - AR_SNOOP 4'b1100 (MakeUnique): RDATA=0, RRESP=OKAY, memory untouched.
  - Other snoop codes: RDATA=mem[idx].
  - Address out of range (AR_ADDR >= DEPTH*4) or AR_LEN!=0: RRESP=SLVERR, RDATA=0.
  - R outputs hold stable until R_READY; on that handshake, return to IDLE next cycle.
- Write path:
  - AW handshake latches address, ID and error flag, then enters WR_DATA.
  - W handshake writes mem[idx]=W_DATA at that edge, unless error or W_LAST=0 (SLVERR, write dropped).
  - B_VALID=1 next cycle; BRESP held stable until B_READY, then IDLE.
  - W_VALID asserted before AW is ignored; W is never accepted in the AW cycle.
- Read-after-write to the same index, issued after B completes, returns the new data.
- Back-to-back transactions: minimum 1 IDLE cycle between the response handshake and the next address handshake.

Optional Feature:
- Macro: ACE_MEM_READY_STALL_EN.
- Defined:
  - 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded with STALL_SEED on reset, advances every cycle.
  - AR_READY, AW_READY and W_READY are additionally ANDed with lfsr[0], injecting pseudo-random wait states.
  - Stalls never change data or ordering.
- Undefined: no LFSR; ready signals exactly as in Behaviour.

Decomposition:
- Package ace_mem_pkg:
  - State enum.
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - SNOOP_READ_SHARED=4'b0001, SNOOP_MAKE_UNIQUE=4'b1100.
- Sub-module ace_mem_array:
  - Async-reset register file with INIT_WORD, one write port, one combinational read port.
  - Instantiated once.

Test Plan:
- Reset, then read 0x0000_0008, AR_SNOOP=0001 -> R_VALID cycle after AR handshake, RDATA=DEEDFEED, RRESP=0000, R_LAST=1.
- Write 0x0000_000C data ABCDABCD, then read 0x0000_000C -> BRESP=00, RDATA=ABCDABCD.
- AR_VALID and AW_VALID asserted together three times -> grants read, write, read; prefer_wr toggles each tie.
- Read 0x0100_0018 and write 0x0100_000C -> RRESP[1:0]=10 with RDATA=0, BRESP=10, memory unchanged.
- Hold R_READY=0 for 5 cycles -> RDATA/RRESP/R_ID stable; AR_READY stays 0 throughout.
- Assert rst while in WR_DATA -> B_VALID=0, all words return to DEEDFEED, next AW accepted.
